// File: rtl/rx_fifo_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rx_fifo_pkg
// Brief    : Shared types and defaults for the receive output FIFO.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package rx_fifo_pkg;

  // One queued byte from the output process block
  typedef logic [7:0] byte_t;

  // Default geometry
  localparam int c_DEPTH_DEFAULT    = 8;
  localparam int c_AF_LEVEL_DEFAULT = 6;

  // Pointer width for a given entry count (never narrower than one bit)
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_fifo_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rx_fifo_mem
// Brief    : Register-file storage for rx_fifo_out. One synchronous write port,
//            one asynchronous read port. Contents are never reset.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module rx_fifo_mem
  import rx_fifo_pkg::*;
#(
  parameter int DEPTH = c_DEPTH_DEFAULT,
  parameter int AW    = ptr_width(c_DEPTH_DEFAULT)
) (
  input  logic          clk2,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  byte_t r_mem [DEPTH];

  // Store the incoming byte at the write address when the write is accepted
  always_ff @(posedge clk2) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/rx_fifo_out.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rx_fifo_out
// Brief    : Byte FIFO between the output process block and the downstream
//            consumer. Zero-latency head read, sticky overflow on dropped
//            writes, synchronous flush, asynchronous active-low reset.
//            Optional feature macro: RX_FIFO_ALMOST_FULL_EN adds the
//            almost_full output (count >= AF_LEVEL).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module rx_fifo_out
  import rx_fifo_pkg::*;
#(
  parameter int DEPTH    = c_DEPTH_DEFAULT,
  parameter int AF_LEVEL = c_AF_LEVEL_DEFAULT
) (
  input  logic                   clk2,
  input  logic                   NReset,
  input  logic [7:0]             wr_data,
  input  logic                   wr_en,
  input  logic                   rd_ready,
  input  logic                   flush,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
`ifdef RX_FIFO_ALMOST_FULL_EN
  ,
  output logic                   almost_full
`endif
);

  localparam int c_AW = ptr_width(DEPTH);
  localparam int c_CW = $clog2(DEPTH) + 1;

  localparam logic [c_AW-1:0] c_PTR_ONE    = 1;
  localparam logic [c_CW-1:0] c_CNT_ONE    = 1;
  localparam logic [c_CW-1:0] c_CNT_FULL   = c_CW'(DEPTH);

  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            r_overflow;

  logic            w_rd_valid;
  logic            w_full;
  logic            w_wr_acc;
  logic            w_rd_acc;
  logic            w_wr_drop;
  logic [7:0]      w_mem_rd;

  // Status comes only from registered state, never from the strobes
  assign w_rd_valid = (r_count != '0);
  assign w_full     = (r_count == c_CNT_FULL);

  // Flush suppresses every transfer in its cycle; a full queue refuses writes
  // even when a read frees an entry on the same edge
  assign w_wr_acc  = wr_en & ~w_full & ~flush;
  assign w_rd_acc  = w_rd_valid & rd_ready & ~flush;
  assign w_wr_drop = wr_en & w_full & ~flush;

  // Pointer, occupancy and sticky overflow update; DEPTH is a power of two so
  // the pointers wrap naturally from DEPTH-1 to 0
  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (c_AW)
  ) u_mem (
    .clk2    (clk2),
    .wr_en   (w_wr_acc),
    .wr_addr (r_wr_ptr),
    .wr_data (wr_data),
    .rd_addr (r_rd_ptr),
    .rd_data (w_mem_rd)
  );

  // Storage is never cleared, so stale bytes are masked while empty
  assign rd_data  = w_rd_valid ? w_mem_rd : 8'h00;
  assign rd_valid = w_rd_valid;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;

`ifdef RX_FIFO_ALMOST_FULL_EN
  localparam logic [c_CW-1:0] c_CNT_AF = c_CW'(AF_LEVEL);
  assign almost_full = (r_count >= c_CNT_AF);
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_fifo_out.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_rx_fifo_out
// Brief    : Self-checking bench for rx_fifo_out: queue-based reference model
//            compared every cycle, plus directed scenarios with literal values.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_rx_fifo_out;

  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = 6;

  logic       clk2 = 1'b0;
  logic       NReset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       rd_ready;
  logic       flush;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic [3:0] count;
  logic       overflow;
`ifdef RX_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  rx_fifo_out #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .clk2     (clk2),
    .NReset   (NReset),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_ready (rd_ready),
    .flush    (flush),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .count    (count),
    .overflow (overflow)
`ifdef RX_FIFO_ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  always #5 clk2 = ~clk2;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of bytes plus the sticky overflow bit
  logic [7:0] m_q [$];
  logic       m_ovf;

  always @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      m_q.delete();
      m_ovf <= 1'b0;
    end else if (flush) begin
      m_q.delete();
      m_ovf <= 1'b0;
    end else begin : upd
      bit do_rd;
      bit do_wr;
      do_rd = (m_q.size() != 0) && rd_ready;
      do_wr = wr_en && (m_q.size() < DEPTH);
      if (wr_en && !do_wr) m_ovf <= 1'b1;
      if (do_rd) void'(m_q.pop_front());
      if (do_wr) m_q.push_back(wr_data);
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk2) begin
    check("mdl_count",    int'(count),    m_q.size());
    check("mdl_rd_valid", int'(rd_valid), int'(m_q.size() != 0));
    check("mdl_full",     int'(full),     int'(m_q.size() == DEPTH));
    check("mdl_rd_data",  int'(rd_data),  (m_q.size() != 0) ? int'(m_q[0]) : 0);
    check("mdl_overflow", int'(overflow), int'(m_ovf));
`ifdef RX_FIFO_ALMOST_FULL_EN
    check("mdl_almost_full", int'(almost_full), int'(m_q.size() >= AF_LEVEL));
`endif
  end

  // Apply one cycle of inputs, then settle just after the edge
  task automatic step(input logic we, input logic [7:0] d, input logic rr, input logic fl);
    wr_en    = we;
    wr_data  = d;
    rd_ready = rr;
    flush    = fl;
    @(posedge clk2);
    #1;
  endtask

  initial begin
    NReset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk2);
    #1;
    check("rst_count",    int'(count),    0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_full",     int'(full),     0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_rd_data",  int'(rd_data),  0);
    NReset = 1'b1;
    step(0, 8'h00, 0, 0);

    // Fill
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
    check("fill_count",    int'(count),    8);
    check("fill_full",     int'(full),     1);
    check("fill_overflow", int'(overflow), 0);
    step(1, 8'hFF, 0, 0);
    check("ovf_set",      int'(overflow), 1);
    check("ovf_count",    int'(count),    8);
    check("ovf_head",     int'(rd_data),  8'h01);

    // Drain
    for (int i = 0; i < 8; i++) begin
      check("drain_data", int'(rd_data), i + 1);
      step(0, 8'h00, 1, 0);
    end
    check("drain_valid",  int'(rd_valid), 0);
    check("drain_data0",  int'(rd_data),  0);
    check("ovf_sticky",   int'(overflow), 1);
    step(0, 8'h00, 0, 0);

    // Concurrent read/write at count 3
    for (int i = 0; i < 3; i++) step(1, 8'(8'h21 + i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      check("conc_data", int'(rd_data), (i < 3) ? (8'h21 + i) : (8'h30 + i - 3));
      step(1, 8'(8'h30 + i), 1, 0);
      check("conc_count", int'(count), 3);
    end
    for (int i = 0; i < 3; i++) begin
      check("conc_tail", int'(rd_data), 8'h37 + i);
      step(0, 8'h00, 1, 0);
    end
    step(0, 8'h00, 0, 0);

    // Wrap: single write then read, pointers cycle through several times
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(8'h10 + i), 0, 0);
      check("wrap_data", int'(rd_data), 8'h10 + i);
      step(0, 8'h00, 1, 0);
    end
    check("wrap_empty", int'(rd_valid), 0);

    // Flush with count 5, overflow still set, concurrent write
    for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 0, 0);
    check("pre_flush_count", int'(count),    5);
    check("pre_flush_ovf",   int'(overflow), 1);
    step(1, 8'hEE, 1, 1);
    check("flush_count", int'(count),    0);
    check("flush_ovf",   int'(overflow), 0);
    check("flush_valid", int'(rd_valid), 0);
    step(1, 8'h77, 0, 0);
    check("post_flush_count", int'(count),   1);
    check("post_flush_head",  int'(rd_data), 8'h77);
    step(0, 8'h00, 1, 0);

    // Reset mid-stream with count 4
    for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 0, 0);
    check("pre_rst_count", int'(count), 4);
    #2;
    NReset = 1'b0;
    #1;
    check("arst_count",    int'(count),    0);
    check("arst_rd_valid", int'(rd_valid), 0);
    check("arst_full",     int'(full),     0);
    check("arst_overflow", int'(overflow), 0);
    check("arst_rd_data",  int'(rd_data),  0);
`ifdef RX_FIFO_ALMOST_FULL_EN
    check("arst_almost_full", int'(almost_full), 0);
`endif
    step(0, 8'h00, 0, 0);
    NReset = 1'b1;
    step(1, 8'hA5, 0, 0);
    check("rel_rd_data",  int'(rd_data),  8'hA5);
    check("rel_rd_valid", int'(rd_valid), 1);
    check("rel_count",    int'(count),    1);

    // Occupancy ramp (almost_full threshold when enabled)
    for (int k = 2; k <= 8; k++) begin
      step(1, 8'(8'hB0 + k), 0, 0);
      check("ramp_count", int'(count), k);
`ifdef RX_FIFO_ALMOST_FULL_EN
      check("af_level", int'(almost_full), (k >= 6) ? 1 : 0);
`endif
    end
    check("ramp_head", int'(rd_data), 8'hA5);

    // Full with simultaneous read: write still dropped
    step(1, 8'hCC, 1, 0);
    check("full_rd_wr_count", int'(count),    7);
    check("full_rd_wr_ovf",   int'(overflow), 1);
    check("full_rd_wr_head",  int'(rd_data),  8'hB2);

    step(0, 8'h00, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_fifo_out.md
RX_FIFO_OUT -- requirements
Module: rx_fifo_out

Interface
REQ-001 Parameters SHALL be:
- DEPTH, 8, number of byte entries; power of two, 4..32.
- AF_LEVEL, 6, almost-full threshold in entries; 1..DEPTH-1.
REQ-002 Ports SHALL be:
- clk2  in  1  system clock; all state changes on the rising edge.
- NReset  in  1  asynchronous, active-low reset.
- wr_data  in  8  byte from the output process block's Output.
- wr_en  in  1  write strobe; one byte per cycle when high.
- rd_ready  in  1  downstream consumer accepts the byte this cycle.
- flush  in  1  synchronous discard of all contents.
- rd_data  out  8  head-of-queue byte.
- rd_valid  out  1  queue not empty; rd_data is meaningful.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: a write was dropped.
- almost_full  out  1  count >= AF_LEVEL; present only with RX_FIFO_ALMOST_FULL_EN.

Function
REQ-003 A write SHALL be accepted when wr_en=1 and full=0: the byte is stored at the write pointer, which advances with wrap from DEPTH-1 to 0.
REQ-004 A read SHALL be accepted when rd_valid=1 and rd_ready=1: the read pointer advances with wrap.
REQ-005 rd_data SHALL be driven combinationally from the entry at the read pointer.
- Zero read latency.
- rd_data = 8'h00 when empty.
REQ-006 Write-to-read latency SHALL be one cycle: a byte written into an empty queue at edge N has rd_valid=1 after edge N.
REQ-007 Simultaneous accepted read and write SHALL leave count unchanged.
- Applies at every occupancy except empty, where only the write is accepted, and full, where only the read is accepted.
REQ-008 A write with full=1 SHALL be dropped and SHALL set overflow.
- The write is dropped even when a read is accepted in the same cycle.
- Stored data and pointers are unaffected.
REQ-009 overflow SHALL remain set until flush or reset.
REQ-010 flush=1 SHALL take priority over wr_en and rd_ready at the next edge.
- Pointers and count go to 0.
- overflow goes to 0.
- No write or read is accepted that cycle.
REQ-011 count, full and rd_valid SHALL be registered or derived only from registered pointers; no combinational path from wr_en or rd_ready.
REQ-012 Storage SHALL NOT be cleared by flush or reset. Only the pointers are cleared.

Reset
REQ-013 NReset=0 SHALL asynchronously set:
- read and write pointers to 0;
- count to 0;
- overflow to 0;
- hence rd_valid=0, full=0, rd_data=8'h00 and almost_full=0.
REQ-014 Reset asserted mid-transfer SHALL discard all queued bytes; the first accepted write after release is the next byte read.

Configuration
REQ-015 With RX_FIFO_ALMOST_FULL_EN defined, the almost_full port and its comparator SHALL exist, asserting while count >= AF_LEVEL.
REQ-016 Without RX_FIFO_ALMOST_FULL_EN, the almost_full port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-017 Package rx_fifo_pkg SHALL hold:
- the byte typedef (8 bits);
- the default DEPTH and AF_LEVEL constants;
- the pointer-width function/constant.
REQ-018 Sub-module rx_fifo_mem SHALL hold the register-file storage: one write port, one asynchronous read port, no reset. Pointer, count and flag logic stays in rx_fifo_out.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Fill: write 8'h01..8'h08 with rd_ready=0 -> count=8, full=1, overflow=0. A ninth write of 8'hFF -> overflow=1, count=8.
- Drain: after fill, hold rd_ready=1 for 8 cycles -> rd_data sequence 01..08, then rd_valid=0, rd_data=00.
- Concurrent: with count=3, assert wr_en and rd_ready together for 10 cycles -> count stays 3 and byte order is preserved.
- Wrap: perform 20 single write/read pairs of 8'h10+i -> each byte read back intact after the pointers wrap.
- Flush: flush with count=5, overflow=1 and wr_en=1 -> next cycle count=0, overflow=0, rd_valid=0, and the concurrent byte is not stored.
- Reset: assert NReset mid-stream with count=4 -> all outputs at reset values immediately. After release, write 8'hA5 -> rd_data=A5 one cycle later. With RX_FIFO_ALMOST_FULL_EN, almost_full rises exactly when count reaches 6.
